// File: rtl/spike_rate_decoder_pkg.sv
// Shared types, widths and the count-to-current saturation used by the spike rate decoder.
`timescale 1ns/1ps
package rate_decoder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int CUR_W = 8;
    localparam logic [CUR_W-1:0] SAT_MAX_DEFAULT = 8'h7F;

    // Widened to 16 bits so a shifted count cannot wrap before the clamp.
    function automatic logic [CUR_W-1:0] saturate_current(
        input logic [7:0]       count,
        input int unsigned      shift,
        input logic [CUR_W-1:0] sat_max
    );
        logic [15:0] wide;
        wide = {8'h00, count} << shift;
        if (wide > {8'h00, sat_max})
            return sat_max;
        return wide[CUR_W-1:0];
    endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Decoded-current result channel: valid/ready with the current value as payload.
`timescale 1ns/1ps
interface spike_rate_decoder_if;
    import rate_decoder_pkg::*;

    logic [CUR_W-1:0] rate_out;
    logic             out_valid;
    logic             out_ready;

    modport master (output rate_out, output out_valid, input out_ready);
    modport slave  (input rate_out, input out_valid, output out_ready);

endinterface

// File: rtl/spike_rate_decoder_window_counter.sv
// Purpose: window FSM counting enabled spikes; flags the last window cycle (RATE_DECODE_LEAKY_EN carries half the count over).
// Latency: window_end/count_final are combinational in the last enabled window cycle.
// Backpressure: none; counting never stalls, enable=0 pauses the window.
`timescale 1ns/1ps
module spike_window_counter
    import rate_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       spike_in,
    input  logic [7:0] window_len,
    output logic       busy,
    output logic       window_end,
    output logic [7:0] count_final
);

    state_t     state;
    logic [7:0] win_cnt;
    logic [7:0] count;
    logic [7:0] count_next;

    assign count_next  = (spike_in && count != 8'hFF) ? count + 8'd1 : count;
    assign window_end  = (state == COUNT) && enable && (win_cnt == 8'd1);
    assign count_final = count_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            win_cnt <= 8'd0;
            count   <= 8'd0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && window_len != 8'd0) begin
                        state   <= COUNT;
                        busy    <= 1'b1;
                        win_cnt <= window_len;
                        count   <= 8'd0;
                    end
                end
                COUNT: begin
                    if (enable) begin
                        if (win_cnt == 8'd1) begin
                            if (window_len != 8'd0) begin
                                // Back-to-back window: no gap cycle.
                                win_cnt <= window_len;
`ifdef RATE_DECODE_LEAKY_EN
                                count   <= count_next >> 1;
`else
                                count   <= 8'd0;
`endif
                            end else begin
                                state   <= IDLE;
                                busy    <= 1'b0;
                                win_cnt <= 8'd0;
                                count   <= 8'd0;
                            end
                        end else begin
                            win_cnt <= win_cnt - 8'd1;
                            count   <= count_next;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Purpose: decodes spike rate over a programmable window into a saturated 8-bit current (RATE_DECODE_LEAKY_EN: leaky estimate).
// Latency: result valid one cycle after the last enabled window cycle.
// Backpressure: source is never stalled; an unconsumed result is overwritten and sticky overrun sets.
`timescale 1ns/1ps
module spike_rate_decoder
    import rate_decoder_pkg::*;
#(
    parameter int unsigned      GAIN_SHIFT = 0,
    parameter logic [CUR_W-1:0] SAT_MAX    = SAT_MAX_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        spike_in,
    input  logic [7:0]                  window_len,
    spike_rate_decoder_if.master        out_bus,
    output logic                        overrun,
    output logic                        busy
);

    logic             window_end;
    logic [7:0]       count_final;
    logic [CUR_W-1:0] rate_q;
    logic             valid_q;

    spike_window_counter u_counter (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .spike_in   (spike_in),
        .window_len (window_len),
        .busy       (busy),
        .window_end (window_end),
        .count_final(count_final)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rate_q  <= '0;
            valid_q <= 1'b0;
            overrun <= 1'b0;
        end else if (window_end) begin
            rate_q  <= saturate_current(count_final, GAIN_SHIFT, SAT_MAX);
            valid_q <= 1'b1;
            // A coincident transfer consumes the old value, so only a stalled one counts as lost.
            if (valid_q && !out_bus.out_ready)
                overrun <= 1'b1;
        end else if (valid_q && out_bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_bus.rate_out  = rate_q;
    assign out_bus.out_valid = valid_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: a cycle table for basic decode plus hand sequences for corner cases.
`timescale 1ns/1ps
module tb_spike_rate_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       spike_in;
    logic [7:0] window_len;
    logic       overrun0, busy0, overrun2, busy2;
    int         total = 0;
    int         bad   = 0;

`ifdef RATE_DECODE_LEAKY_EN
    localparam logic [7:0] LEAKY_EXP = 8'h02;
`else
    localparam logic [7:0] LEAKY_EXP = 8'h00;
`endif

    always #5 clk = ~clk;

    spike_rate_decoder_if bus0 ();
    spike_rate_decoder_if bus2 ();

    spike_rate_decoder #(.GAIN_SHIFT(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
        .window_len(window_len), .out_bus(bus0), .overrun(overrun0), .busy(busy0)
    );

    spike_rate_decoder #(.GAIN_SHIFT(2)) dut_g2 (
        .clk(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
        .window_len(window_len), .out_bus(bus2), .overrun(overrun2), .busy(busy2)
    );

    typedef struct {
        logic       rst, en, sp;
        logic [7:0] wl;
        logic       rdy;
        logic       vld;
        logic [7:0] rate;
        logic       bsy;
        logic       ovr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, en, sp, input logic [7:0] wl, input logic rdy,
                                input logic vld, input logic [7:0] rate, input logic bsy, ovr);
        vec_t v;
        v.rst = rst; v.en = en; v.sp = sp; v.wl = wl; v.rdy = rdy;
        v.vld = vld; v.rate = rate; v.bsy = bsy; v.ovr = ovr;
        return v;
    endfunction

    task automatic step(input logic r, e, s, input logic [7:0] w, input logic rd);
        @(negedge clk);
        reset = r; enable = e; spike_in = s; window_len = w;
        bus0.out_ready = rd; bus2.out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic vld, input logic [7:0] rate,
                             input logic bsy, input logic ovr);
        check({tag, ".out_valid"}, {7'd0, bus0.out_valid}, {7'd0, vld});
        check({tag, ".rate_out"},  bus0.rate_out, rate);
        check({tag, ".busy"},      {7'd0, busy0}, {7'd0, bsy});
        check({tag, ".overrun"},   {7'd0, overrun0}, {7'd0, ovr});
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; spike_in = 1'b0; window_len = 8'd0;
        bus0.out_ready = 1'b1; bus2.out_ready = 1'b1;

        // Basic decode: window_len=10, spikes on odd counted cycles, window_len dropped to 0 after start.
        vecs.push_back(mk(1, 0, 0, 8'd0,  1, 0, 8'h00, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'd10, 1, 0, 8'h00, 1, 0));
        for (int c = 1; c <= 10; c++)
            vecs.push_back(mk(0, 1, logic'(c % 2), 8'd0, 1, logic'(c == 10),
                              (c == 10) ? 8'h05 : 8'h00, logic'(c != 10), 0));
        vecs.push_back(mk(0, 0, 0, 8'd0, 1, 0, 8'h05, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].sp, vecs[i].wl, vecs[i].rdy);
            check_out($sformatf("basic[%0d]", i), vecs[i].vld, vecs[i].rate, vecs[i].bsy, vecs[i].ovr);
        end

        // Saturation: 100 spikes -> 100 at gain 1, 400 clamped to 0x7F at gain 4.
        step(1, 0, 0, 8'd0, 1);
        step(0, 1, 1, 8'd100, 1);
        for (int i = 1; i <= 100; i++) begin
            step(0, 1, 1, 8'd0, 1);
            if (i == 99) check("sat.early_valid", {7'd0, bus0.out_valid}, 8'd0);
        end
        check("sat.g0.rate",  bus0.rate_out, 8'h64);
        check("sat.g0.valid", {7'd0, bus0.out_valid}, 8'd1);
        check("sat.g2.rate",  bus2.rate_out, 8'h7F);
        check("sat.g2.valid", {7'd0, bus2.out_valid}, 8'd1);

        // Pause: spikes during enable=0 are ignored and the window is held open.
        step(1, 0, 0, 8'd0, 1);
        step(0, 1, 0, 8'd4, 1);
        step(0, 1, 1, 8'd0, 1);
        step(0, 1, 0, 8'd0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 8'd0, 1);
            check_out($sformatf("pause.hold[%0d]", i), 0, 8'h00, 1, 0);
        end
        step(0, 1, 1, 8'd0, 1);
        check_out("pause.c3", 0, 8'h00, 1, 0);
        step(0, 1, 0, 8'd0, 1);
        check_out("pause.end", 1, 8'h02, 0, 0);

        // Overrun: two windows complete with out_ready low.
        step(1, 0, 0, 8'd0, 0);
        step(0, 1, 0, 8'd3, 0);
        step(0, 1, 1, 8'd3, 0);
        step(0, 1, 0, 8'd3, 0);
        step(0, 1, 0, 8'd3, 0);
        check_out("ovr.first", 1, 8'h01, 1, 0);
        step(0, 1, 1, 8'd0, 0);
        check_out("ovr.stable", 1, 8'h01, 1, 0);
        step(0, 1, 1, 8'd0, 0);
        step(0, 1, 0, 8'd0, 0);
        check_out("ovr.second", 1, 8'h02, 0, 1);
        step(0, 0, 0, 8'd0, 1);
        check_out("ovr.drain", 0, 8'h02, 0, 1);
        step(0, 0, 0, 8'd0, 1);
        check_out("ovr.sticky", 0, 8'h02, 0, 1);

        // Reset mid-window discards the partial count.
        step(0, 1, 0, 8'd10, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 8'd10, 1);
        check_out("rst.mid", 0, 8'h02, 1, 1);
        step(1, 1, 1, 8'd10, 1);
        check_out("rst.after", 0, 8'h00, 0, 0);
        step(0, 1, 0, 8'd2, 1);
        step(0, 1, 1, 8'd0, 1);
        step(0, 1, 0, 8'd0, 1);
        check_out("rst.next", 1, 8'h01, 0, 0);

        // Leaky carry-over: full window then an empty back-to-back window.
        step(1, 0, 0, 8'd0, 1);
        step(0, 1, 0, 8'd4, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 8'd4, 1);
        check_out("leaky.first", 1, 8'h04, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'd0, 1);
        check_out("leaky.second", 1, LEAKY_EXP, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
